udp_tx_app_responder: RTL
=========================

UDP_TX_APP_RESPONDER -- requirements
Module: udp_tx_app_responder

Interface
REQ-001 SHALL have parameter SRC_PORT, default 16'd8080, the UDP source port placed in header bytes 0-1.
REQ-002 SHALL have parameter DST_PORT, default 16'd8080, the UDP destination port placed in header bytes 2-3.
REQ-003 SHALL have port app_tx_clk  in  1  clock; all logic is synchronous to its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port app_tx_data_request  in  1  application requests a transmit slot.
REQ-006 SHALL have port app_tx_data  in  8  payload byte.
REQ-007 SHALL have port app_tx_data_valid  in  1  payload byte qualifier.
REQ-008 SHALL have port udp_data_length  in  16  payload byte count; valid while app_tx_data_valid is high.
REQ-009 SHALL have port ip_tx_ready  in  1  downstream IP layer can accept a datagram.
REQ-010 SHALL have port udp_tx_ready  out  1  block can accept a new request.
REQ-011 SHALL have port app_tx_ack  out  1  one-cycle grant of the request.
REQ-012 SHALL have port udp_tx_data  out  8  datagram byte (header, then payload).
REQ-013 SHALL have port udp_tx_valid  out  1  udp_tx_data qualifier; no backpressure.
REQ-014 SHALL have port udp_tx_sof  out  1  high with header byte 0.
REQ-015 SHALL have port udp_tx_eof  out  1  high with the last byte of the datagram.
REQ-016 SHALL have port len_err  out  1  one-cycle pulse on a payload length mismatch.

Function
REQ-017 SHALL implement the states IDLE, ACK, WAIT_DATA, HEADER, PAYLOAD, and GAP.
REQ-018 IDLE: udp_tx_ready SHALL equal ip_tx_ready; when app_tx_data_request=1 and ip_tx_ready=1, the block SHALL assert app_tx_ack for exactly one cycle and move to ACK.
REQ-019 ACK -> WAIT_DATA SHALL occur unconditionally, and udp_tx_ready SHALL be 0 in every state other than IDLE.
REQ-020 WAIT_DATA: on the first app_tx_data_valid=1, the block SHALL capture udp_data_length into len_q, write the byte into the payload FIFO, and enter HEADER.
REQ-021 WAIT_DATA: if no valid byte arrives within 16 cycles, the block SHALL return to IDLE, emit nothing, and (with the macro) pulse len_err.
REQ-022 HEADER SHALL emit 8 bytes on consecutive cycles, starting the cycle after capture: SRC_PORT[15:8], SRC_PORT[7:0], DST_PORT[15:8], DST_PORT[7:0], (len_q+8)[15:8], (len_q+8)[7:0], 8'h00, 8'h00.
REQ-023 The header length field SHALL be computed in 16 bits and wrap modulo 2^16; the checksum field SHALL be 0.
REQ-024 While header bytes are emitted, incoming valid bytes SHALL be written to a 16-entry payload FIFO.
REQ-025 PAYLOAD SHALL pop one byte per cycle until exactly len_q bytes have been emitted; bytes arriving beyond len_q SHALL be discarded.
REQ-026 If len_q=0, the captured byte SHALL be discarded, udp_tx_eof SHALL coincide with header byte 7, and PAYLOAD SHALL be skipped.
REQ-027 A FIFO write and a FIFO read in the same cycle SHALL both take effect; the FIFO never overflows because the lag is at most 9 bytes.
REQ-028 After the eof byte the block SHALL enter GAP, hold for 2 cycles, and then return to IDLE.
REQ-029 app_tx_data_request asserted outside IDLE SHALL be ignored until the block is back in IDLE.

Reset
REQ-030 While reset is high, all outputs SHALL be 0, the state SHALL be IDLE, and the FIFO pointers, len_q, and all counters SHALL be 0.
REQ-031 Reset asserted mid-datagram SHALL abort the datagram with no eof; after release the block SHALL resume from IDLE with no residual payload bytes.

Configuration
REQ-032 With macro UDP_TX_LEN_CHECK_EN defined, the block SHALL count the valid bytes received until app_tx_data_valid falls, and SHALL pulse len_err for one cycle at the falling edge if that count differs from len_q (including the WAIT_DATA timeout case).
REQ-033 Without UDP_TX_LEN_CHECK_EN, len_err SHALL be tied to 0 and no counting logic SHALL be built; all other behaviour SHALL be identical.

Verification
REQ-034 Request, ip_tx_ready=1, length 4, payload 11 22 33 44 -> ack 1 cycle; output 1F 90 1F 90 00 0C 00 00 11 22 33 44; sof on byte 0, eof on 44; no gaps in valid.
REQ-035 Request while ip_tx_ready=0 for 5 cycles, then 1 -> no ack and udp_tx_ready=0 during the 5 cycles; ack on the first cycle the block samples ready=1.
REQ-036 Length 0 with one valid byte -> 8-byte header with length field 00 08; eof on byte 7; no payload emitted.
REQ-037 Length 3 with 5 valid bytes (macro on) -> 3 payload bytes emitted; len_err pulses once; with the macro off, len_err stays 0.
REQ-038 Reset asserted at payload byte 2 of 10 -> all outputs 0 immediately; a subsequent length-2 datagram contains only its own 2 bytes.
REQ-039 Back-to-back requests -> second ack no earlier than 3 cycles after the first eof; the 16-cycle no-data timeout returns the block to IDLE.

Source files
------------

// File: rtl/udp_tx_app_responder.sv
// Frames one application payload per granted request into a UDP datagram (8-byte header + payload).
// Define UDP_TX_LEN_CHECK_EN to build the received-byte-count versus declared-length check on len_err.
module udp_tx_app_responder #(
  parameter logic [15:0] SRC_PORT = 16'd8080,
  parameter logic [15:0] DST_PORT = 16'd8080
) (
  input  logic        app_tx_clk,
  input  logic        reset,
  input  logic        app_tx_data_request,
  input  logic [7:0]  app_tx_data,
  input  logic        app_tx_data_valid,
  input  logic [15:0] udp_data_length,
  input  logic        ip_tx_ready,
  output logic        udp_tx_ready,
  output logic        app_tx_ack,
  output logic [7:0]  udp_tx_data,
  output logic        udp_tx_valid,
  output logic        udp_tx_sof,
  output logic        udp_tx_eof,
  output logic        len_err
);

  typedef enum logic [2:0] {IDLE, ACK, WAIT_DATA, HEADER, PAYLOAD, GAP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  wait_cnt;
  logic [2:0]  hdr_cnt;
  logic        gap_cnt;
  logic [15:0] len_q, rx_cnt, tx_cnt;
  logic [7:0]  fifo_mem [16];
  logic [3:0]  wr_ptr, rd_ptr;
  logic [4:0]  fifo_cnt;
  logic        capture, timeout, fifo_wr, fifo_rd, pay_last;

  function automatic logic [7:0] hdr_byte(input logic [2:0] idx, input logic [15:0] len);
    logic [15:0] total;
    total = len + 16'd8;
    case (idx)
      3'd0:    hdr_byte = SRC_PORT[15:8];
      3'd1:    hdr_byte = SRC_PORT[7:0];
      3'd2:    hdr_byte = DST_PORT[15:8];
      3'd3:    hdr_byte = DST_PORT[7:0];
      3'd4:    hdr_byte = total[15:8];
      3'd5:    hdr_byte = total[7:0];
      default: hdr_byte = 8'h00;
    endcase
  endfunction

  assign capture  = (state_q == WAIT_DATA) && app_tx_data_valid;
  assign timeout  = (state_q == WAIT_DATA) && !app_tx_data_valid && (wait_cnt == 4'd15);
  assign fifo_rd  = (state_q == PAYLOAD) && (fifo_cnt != 5'd0);
  assign pay_last = fifo_rd && (tx_cnt == len_q - 16'd1);
  // Bytes past the declared length never enter the FIFO, so nothing is left over for the next datagram.
  assign fifo_wr  = capture ? (udp_data_length != 16'd0)
                            : ((state_q == HEADER || state_q == PAYLOAD) &&
                               app_tx_data_valid && (rx_cnt < len_q));

  assign udp_tx_ready = (state_q == IDLE) && ip_tx_ready && !reset;
  assign app_tx_ack   = (state_q == ACK);

  always_ff @(posedge app_tx_clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: assigning the default first keeps every path driven, so no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:      if (app_tx_data_request && ip_tx_ready) state_d = ACK;
      ACK:       state_d = WAIT_DATA;
      WAIT_DATA: if (capture) state_d = HEADER;
                 else if (timeout) state_d = IDLE;
      HEADER:    if (hdr_cnt == 3'd7) state_d = (len_q == 16'd0) ? GAP : PAYLOAD;
      PAYLOAD:   if (pay_last) state_d = GAP;
      GAP:       if (gap_cnt) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: the payload store has no reset; wr_ptr/rd_ptr/fifo_cnt alone decide which entries are live.
  always_ff @(posedge app_tx_clk) begin
    if (fifo_wr) fifo_mem[wr_ptr] <= app_tx_data;
  end

  always_ff @(posedge app_tx_clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      wait_cnt     <= 4'd0;
      hdr_cnt      <= 3'd0;
      gap_cnt      <= 1'b0;
      len_q        <= 16'd0;
      rx_cnt       <= 16'd0;
      tx_cnt       <= 16'd0;
      wr_ptr       <= 4'd0;
      rd_ptr       <= 4'd0;
      fifo_cnt     <= 5'd0;
      udp_tx_data  <= 8'h00;
      udp_tx_valid <= 1'b0;
      udp_tx_sof   <= 1'b0;
      udp_tx_eof   <= 1'b0;
    end else begin
      udp_tx_data  <= 8'h00;
      udp_tx_valid <= 1'b0;
      udp_tx_sof   <= 1'b0;
      udp_tx_eof   <= 1'b0;
      wait_cnt     <= (state_q == WAIT_DATA) ? wait_cnt + 4'd1 : 4'd0;
      gap_cnt      <= (state_q == GAP) ? ~gap_cnt : 1'b0;

      // Header byte 0 leaves on the capture edge so the header starts the very next cycle.
      if (capture) begin
        len_q        <= udp_data_length;
        rx_cnt       <= {15'd0, fifo_wr};
        tx_cnt       <= 16'd0;
        hdr_cnt      <= 3'd1;
        udp_tx_data  <= hdr_byte(3'd0, udp_data_length);
        udp_tx_valid <= 1'b1;
        udp_tx_sof   <= 1'b1;
      end else if (fifo_wr) begin
        rx_cnt <= rx_cnt + 16'd1;
      end

      if (state_q == HEADER) begin
        hdr_cnt      <= hdr_cnt + 3'd1;
        udp_tx_data  <= hdr_byte(hdr_cnt, len_q);
        udp_tx_valid <= 1'b1;
        udp_tx_eof   <= (hdr_cnt == 3'd7) && (len_q == 16'd0);
      end

      if (fifo_rd) begin
        udp_tx_data  <= fifo_mem[rd_ptr];
        udp_tx_valid <= 1'b1;
        udp_tx_eof   <= pay_last;
        tx_cnt       <= tx_cnt + 16'd1;
        rd_ptr       <= rd_ptr + 4'd1;
      end

      if (fifo_wr) wr_ptr <= wr_ptr + 4'd1;
      fifo_cnt <= fifo_cnt + 5'(fifo_wr) - 5'(fifo_rd);
    end
  end

`ifdef UDP_TX_LEN_CHECK_EN
  logic        chk_active;
  logic [15:0] vld_cnt;
  logic        len_err_q;

  // Counts the burst that began at capture; compares when app_tx_data_valid first drops.
  always_ff @(posedge app_tx_clk or posedge reset) begin
    if (reset) begin
      chk_active <= 1'b0;
      vld_cnt    <= 16'd0;
      len_err_q  <= 1'b0;
    end else begin
      len_err_q <= timeout;
      if (capture) begin
        chk_active <= 1'b1;
        vld_cnt    <= 16'd1;
      end else if (chk_active) begin
        if (app_tx_data_valid) begin
          vld_cnt <= vld_cnt + 16'd1;
        end else begin
          chk_active <= 1'b0;
          len_err_q  <= (vld_cnt != len_q);
        end
      end
    end
  end

  assign len_err = len_err_q;
`else
  assign len_err = 1'b0;
`endif

endmodule
